// File: rtl/controle_fechadura_if.sv
// Keypad-decoder to lock-controller link: password pack, strobe and keypad enable.
interface controle_fechadura_if;
  localparam int unsigned PACK_W = 80;

  logic [PACK_W-1:0] digitos_value;
  logic              digitos_valid;
  logic              teclado_en;

  // Keypad decoder side
  modport master (
    output digitos_value,
    output digitos_valid,
    input  teclado_en
  );

  // Lock controller side
  modport slave (
    input  digitos_value,
    input  digitos_valid,
    output teclado_en
  );
endinterface

// File: rtl/controle_fechadura.sv
// Lock controller: validates keypad password packs against the user and master
// passwords, drives the lock, counts failures, handles lockout and reprogramming.
module controle_fechadura #(
  parameter logic [79:0] SENHA_PADRAO = 80'h4321FFFFFFFFFFFFFFFF,
  parameter int unsigned MIN_DIG      = 4,
  parameter int unsigned MAX_DIG      = 12,
  parameter int unsigned MAX_TENT     = 3,
  parameter int unsigned T_ABERTO     = 1000,
  parameter int unsigned T_ERRO       = 200,
  parameter int unsigned T_BLOQ       = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  controle_fechadura_if.slave  kbd,
  input  logic [79:0]          senha_master_i,
  output logic                 tranca_aberta_o,
  output logic                 led_erro_o,
  output logic                 bloqueado_o,
  output logic                 modo_config_o,
  output logic [2:0]           tentativas_o
);

  localparam int unsigned PACK_W  = 80;
  localparam int unsigned N_DIG   = 20;
  localparam int unsigned T_MAX_A = (T_ABERTO > T_ERRO) ? T_ABERTO : T_ERRO;
  localparam int unsigned T_MAX   = (T_MAX_A > T_BLOQ) ? T_MAX_A : T_BLOQ;
  localparam int unsigned TIMER_W = $clog2(T_MAX + 1);
  localparam int unsigned TENT_W  = 3;

  typedef enum logic [2:0] {
    OCIOSO,
    VERIFICA,
    ABERTO,
    ERRO,
    BLOQUEIO,
    CONFIG,
    CONFIG_GRAVA
  } estado_t;

  typedef struct packed {
    logic cancel;
    logic timeout;
    logic vazio;
    logic bem_formado;
  } classe_t;

  estado_t              state_q, state_d;
  logic [PACK_W-1:0]    senha_q, senha_d;
  logic [PACK_W-1:0]    pack_q, pack_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TENT_W-1:0]    tent_q, tent_d;
  logic                 teclado_en_q, teclado_en_d;
  logic                 tranca_q, tranca_d;
  logic                 led_erro_q, led_erro_d;
  logic                 bloq_q, bloq_d;
  logic                 modo_cfg_q, modo_cfg_d;

  classe_t              entrada_c;
  classe_t              capturado_c;
  logic [TENT_W-1:0]    tent_inc_c;

  // Classifies a pack: special all-B/all-E/all-F codes and the well-formed test.
  function automatic classe_t classifica(input logic [PACK_W-1:0] p);
    classe_t    c;
    logic [4:0] n;
    logic       fim;
    logic       ok;
    logic [3:0] d;
    c       = '0;
    n       = '0;
    fim     = 1'b0;
    ok      = 1'b1;
    c.cancel  = (p == {N_DIG{4'hB}});
    c.timeout = (p == {N_DIG{4'hE}});
    c.vazio   = (p == {N_DIG{4'hF}});
    for (int i = N_DIG - 1; i >= 0; i--) begin
      d = p[i*4 +: 4];
      if (!fim && d != 4'hF) begin
        n = n + 5'd1;
        if (d > 4'd9) ok = 1'b0;
      end else begin
        fim = 1'b1;
        if (d != 4'hF) ok = 1'b0;
      end
    end
    c.bem_formado = ok && (32'(n) >= MIN_DIG) && (32'(n) <= MAX_DIG);
    return c;
  endfunction

  assign entrada_c   = classifica(kbd.digitos_value);
  assign capturado_c = classifica(pack_q);
  assign tent_inc_c  = (32'(tent_q) >= MAX_TENT) ? TENT_W'(MAX_TENT) : tent_q + 3'd1;

  // State, storage and registered outputs; synchronous reset has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OCIOSO;
      senha_q      <= SENHA_PADRAO;
      pack_q       <= '0;
      timer_q      <= '0;
      tent_q       <= '0;
      teclado_en_q <= 1'b1;
      tranca_q     <= 1'b0;
      led_erro_q   <= 1'b0;
      bloq_q       <= 1'b0;
      modo_cfg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      senha_q      <= senha_d;
      pack_q       <= pack_d;
      timer_q      <= timer_d;
      tent_q       <= tent_d;
      teclado_en_q <= teclado_en_d;
      tranca_q     <= tranca_d;
      led_erro_q   <= led_erro_d;
      bloq_q       <= bloq_d;
      modo_cfg_q   <= modo_cfg_d;
    end
  end

  // Next-state, timer, failure counter and output decode from the next state.
  always_comb begin
    state_d = state_q;
    senha_d = senha_q;
    pack_d  = pack_q;
    timer_d = timer_q;
    tent_d  = tent_q;

    case (state_q)
      OCIOSO: begin
        if (kbd.digitos_valid &&
            !(entrada_c.cancel || entrada_c.timeout || entrada_c.vazio)) begin
          pack_d  = kbd.digitos_value;
          state_d = VERIFICA;
        end
      end
      VERIFICA: begin
        if (capturado_c.bem_formado && pack_q == senha_master_i) begin
          tent_d  = '0;
          state_d = CONFIG;
        end else if (capturado_c.bem_formado && pack_q == senha_q) begin
          tent_d  = '0;
          timer_d = TIMER_W'(T_ABERTO);
          state_d = ABERTO;
        end else begin
          tent_d = tent_inc_c;
          if (32'(tent_inc_c) == MAX_TENT) begin
            timer_d = TIMER_W'(T_BLOQ);
            state_d = BLOQUEIO;
          end else begin
            timer_d = TIMER_W'(T_ERRO);
            state_d = ERRO;
          end
        end
      end
      ABERTO, ERRO: begin
        if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
          state_d = OCIOSO;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      BLOQUEIO: begin
        if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
          tent_d  = '0;
          state_d = OCIOSO;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      CONFIG: begin
        if (kbd.digitos_valid) begin
          if (entrada_c.cancel || entrada_c.timeout) begin
            state_d = OCIOSO;
          end else if (entrada_c.vazio) begin
            state_d = CONFIG;
          end else if (entrada_c.bem_formado) begin
            pack_d  = kbd.digitos_value;
            state_d = CONFIG_GRAVA;
          end else begin
            timer_d = TIMER_W'(T_ERRO);
            state_d = ERRO;
          end
        end
      end
      CONFIG_GRAVA: begin
        senha_d = pack_q;
        state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase

    teclado_en_d = !(state_d == ABERTO || state_d == ERRO || state_d == BLOQUEIO);
    tranca_d     = (state_d == ABERTO);
    led_erro_d   = (state_d == ERRO || state_d == BLOQUEIO);
    bloq_d       = (state_d == BLOQUEIO);
    modo_cfg_d   = (state_d == CONFIG);
  end

  assign kbd.teclado_en  = teclado_en_q;
  assign tranca_aberta_o = tranca_q;
  assign led_erro_o      = led_erro_q;
  assign bloqueado_o     = bloq_q;
  assign modo_config_o   = modo_cfg_q;
  assign tentativas_o    = tent_q;

endmodule
